// File: rtl/button_step_pkg.sv
// ---------------------------------------------------------------------------
// button_step_pkg : shared FSM encoding and direction constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package button_step_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    REPEAT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_step_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// debounce_filter : synchroniser plus stable-count debounce for one button
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Level flips on the DEB_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_W'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= synced;
        rise  <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_step_ctrl.sv
// ---------------------------------------------------------------------------
// button_step_ctrl : debounced up/down buttons to step pulses with auto-repeat
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_step_ctrl
  import button_step_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic repeat_en,
  output logic step_en,
  output logic step_dir,
  output logic busy
);

  localparam int TMR_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic up_level, up_rise, dn_level, dn_rise;

  debounce_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb_up (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_up),
    .level   (up_level),
    .rise    (up_rise)
  );

  debounce_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_down),
    .level   (dn_level),
    .rise    (dn_rise)
  );

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n, timer_inc;
  logic             dir_n, step_n;
  logic             active_lvl, other_rise;

  assign active_lvl = (step_dir == DIR_DOWN) ? dn_level : up_level;
  assign other_rise = (step_dir == DIR_DOWN) ? up_rise  : dn_rise;
  assign timer_inc  = (timer == TMR_W'(TMR_MAX)) ? timer : timer + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      step_en  <= 1'b0;
      step_dir <= DIR_UP;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      step_en  <= step_n;
      step_dir <= dir_n;
      busy     <= (state_n != IDLE);
    end
  end

  // A rising opposite button outranks a release, so no level is left
  // held in IDLE without having produced a rise strobe.
  always_comb begin
    state_n = state;
    timer_n = timer_inc;
    dir_n   = step_dir;
    step_n  = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if ((up_rise && (dn_rise || dn_level)) || (dn_rise && up_level)) begin
          state_n = LOCKOUT;
        end else if (up_rise) begin
          step_n  = 1'b1;
          dir_n   = DIR_UP;
          state_n = DELAY;
        end else if (dn_rise) begin
          step_n  = 1'b1;
          dir_n   = DIR_DOWN;
          state_n = DELAY;
        end
      end
      DELAY: begin
        if (other_rise) begin
          state_n = LOCKOUT;
          timer_n = '0;
        end else if (!active_lvl) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (repeat_en && (timer >= TMR_W'(REPEAT_DELAY - 1))) begin
          step_n  = 1'b1;
          state_n = REPEAT;
          timer_n = '0;
        end
      end
      REPEAT: begin
        if (other_rise) begin
          state_n = LOCKOUT;
          timer_n = '0;
        end else if (!active_lvl) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (repeat_en && (timer >= TMR_W'(REPEAT_PERIOD - 1))) begin
          step_n  = 1'b1;
          timer_n = '0;
        end
      end
      LOCKOUT: begin
        timer_n = '0;
        if (!up_level && !dn_level) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
